// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared width and FSM encoding for the register write arbiter
package reg_write_arbiter_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - rotating first-set picker starting at a given index
module reg_write_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j     = 0;
    jj    = '0;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      // start is always a valid index, so one modulo keeps the scan in range
      j  = (int'(start) + k) % N;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found    = 1'b1;
        pick[jj] = 1'b1;
        idx      = jj;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin owner of the shared 16-bit register write port
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 2,
  localparam int IW = $clog2(NUM_REQ),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         q,
  output logic                      q_wr,
  output logic [IW-1:0]             owner,
  output logic                      busy
);

  state_t              state, state_nxt;
  logic [IW-1:0]       ptr, ptr_nxt, owner_inc, scan_start, pick_idx, win_idx;
  logic [HW-1:0]       hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0]  owner_oh, scan_req, pick;
  logic                pick_found, win, use_pick;

  assign owner_inc  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
  assign owner_oh   = NUM_REQ'(1) << owner;
  // During a burst the owner is masked so the scan only finds true contenders
  assign scan_req   = (state == ST_OWN) ? (req & ~owner_oh) : req;
  assign scan_start = (state == ST_OWN) ? owner_inc : ptr;

  reg_write_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (scan_req),
    .start (scan_start),
    .pick  (pick),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= win_idx;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    win       = 1'b0;
    use_pick  = 1'b0;
    win_idx   = owner;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          win       = 1'b1;
          use_pick  = 1'b1;
          win_idx   = pick_idx;
          hold_nxt  = HW'(1);
          state_nxt = ST_OWN;
        end
      end
      ST_OWN: begin
        if (req[owner] && (hold_cnt < HW'(MAX_HOLD))) begin
          win      = 1'b1;
          hold_nxt = hold_cnt + HW'(1);
        end else if (pick_found) begin
          win      = 1'b1;
          use_pick = 1'b1;
          win_idx  = pick_idx;
          hold_nxt = HW'(1);
        end else if (req[owner]) begin
          // hold expired but nobody else wants the port: start a fresh burst
          win      = 1'b1;
          hold_nxt = HW'(1);
        end else begin
          state_nxt = ST_IDLE;
          ptr_nxt   = owner_inc;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (!rst && win) gnt = use_pick ? pick : owner_oh;
    busy = (state == ST_OWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      q_wr <= 1'b0;
    end else begin
      q_wr <= win;
      if (win) q <= wdata[win_idx*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed and randomized checks of reg_write_arbiter against a reference model
module tb_reg_write_arbiter;

  localparam int N     = 4;
  localparam int MAX   = 2;
  localparam int BOUND = (N - 1) * MAX;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*16-1:0] wdata;
  logic [N-1:0]  gnt;
  logic [15:0]   q;
  logic          q_wr;
  logic [1:0]    owner;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  int       m_active = 0;
  int       m_owner  = 0;
  int       m_ptr    = 0;
  int       m_run    = 0;
  int       m_q      = 0;
  int       m_qwr    = 0;
  int       last_g   = -1;
  int       waits[N];
  int       seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  reg_write_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAX)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .q_wr  (q_wr),
    .owner (owner),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whose turn it is, derived from the round-robin / burst rules
  function automatic int model_pick();
    int j;
    if (m_active == 0) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (req[j]) return j;
      end
      return -1;
    end
    if (req[m_owner] && m_run < MAX) return m_owner;
    for (int k = 1; k < N; k++) begin
      j = (m_owner + k) % N;
      if (req[j]) return j;
    end
    if (req[m_owner]) return m_owner;
    return -1;
  endfunction

  task automatic set_data(input int i, input logic [15:0] v);
    wdata[i*16 +: 16] = v;
  endtask

  task automatic step();
    int g;
    logic [N-1:0] eg;
    #10;
    g  = model_pick();
    eg = '0;
    if (!rst && g >= 0) eg[g] = 1'b1;
    check("gnt", 32'(gnt), 32'(eg));
    @(posedge clk);
    if (!rst && g >= 0) check("wait_bound", 32'(waits[g] <= BOUND), 32'd1);
    for (int i = 0; i < N; i++)
      waits[i] = (!rst && req[i] && g != i) ? waits[i] + 1 : 0;
    if (rst) begin
      m_active = 0; m_owner = 0; m_ptr = 0; m_run = 0; m_q = 0; m_qwr = 0;
      last_g = -1;
    end else if (g >= 0) begin
      m_q   = int'(wdata[g*16 +: 16]);
      m_qwr = 1;
      m_run = (m_active != 0 && g == m_owner) ? ((m_run < MAX) ? m_run + 1 : 1) : 1;
      m_owner  = g;
      m_active = 1;
      last_g   = g;
    end else begin
      m_qwr = 0;
      if (m_active != 0) m_ptr = (m_owner + 1) % N;
      m_active = 0;
      last_g   = -1;
    end
    #1;
    check("q", 32'(q), 32'(m_q));
    check("q_wr", 32'(q_wr), 32'(m_qwr));
    check("owner", 32'(owner), 32'(m_owner));
    check("busy", 32'(busy), 32'(m_active));
  endtask

  initial begin
    for (int i = 0; i < N; i++) waits[i] = 0;
    rst = 1'b1; req = 4'b1111; wdata = '0;
    step(); step();
    check("rst_q", 32'(q), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    rst = 1'b0; req = 4'b0100; set_data(2, 16'h0013);
    step();
    check("single_q", 32'(q), 32'h0013);
    check("single_owner", 32'(owner), 32'd2);
    req = 4'b0000;
    step();
    check("idle_busy", 32'(busy), 32'h0);
    req = 4'b1001; set_data(0, 16'h0044); set_data(3, 16'h0055);
    step();
    check("ptr_after_idle", 32'(q), 32'h0055);

    rst = 1'b1; req = 4'b0000;
    step();
    rst = 1'b0; req = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, 16'h0010 + 16'(i));
    for (int k = 0; k < 9; k++) begin
      step();
      check("rr_seq", 32'(q), 32'h10 + 32'(seq[k]));
    end

    rst = 1'b1; req = 4'b0000;
    step();
    rst = 1'b0; req = 4'b0001; set_data(0, 16'h0031);
    for (int k = 0; k < 5; k++) begin
      step();
      check("solo_wr", 32'(q_wr), 32'd1);
    end

    rst = 1'b1; req = 4'b0000;
    step();
    rst = 1'b0; req = 4'b1000; set_data(3, 16'h0033); set_data(0, 16'h0030);
    step();
    req = 4'b1001;
    step(); step();
    check("wrap_owner", 32'(owner), 32'd0);

    req = 4'b0010; set_data(1, 16'h0001); rst = 1'b1;
    step();
    check("rst_mid_q", 32'(q), 32'h0);
    check("rst_mid_wr", 32'(q_wr), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_q", 32'(q), 32'h0001);

    req = 4'b0000;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (last_g == i) begin
            if ($urandom_range(0, 1) == 1) set_data(i, 16'($urandom));
            else req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_data(i, 16'($urandom));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
